// File: rtl/cas_fsk_player.sv
// MSX 1200/2400 Hz FSK cassette transmitter: turns tagged header/data items into
// the 1-bit tape signal, paced by the 3.58 MHz enable and gated by the motor bit.
module cas_fsk_player #(
    parameter int HALF_P    = 746,
    parameter int LONG_HDR  = 16000,
    parameter int SHORT_HDR = 4000
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       ce_i,
    input  logic       motor_i,
    input  logic       abort_i,
    input  logic [7:0] data_i,
    input  logic [1:0] tag_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       cas_audio_o,
    output logic       busy_o
);
    localparam int SEG_W = $clog2(2 * HALF_P + 1);
    localparam logic [SEG_W-1:0] SEG_SHORT = SEG_W'(HALF_P);
    localparam logic [SEG_W-1:0] SEG_LONG  = SEG_W'(2 * HALF_P);

    typedef enum logic [2:0] {IDLE, HDR, START, DATA, STOP} StateT;

    StateT            state_q, state_d;
    logic             level_q, level_d;
    logic [SEG_W-1:0] segCnt_q, segCnt_d;
    logic [1:0]       segIdx_q, segIdx_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [15:0]      hdrCnt_q, hdrCnt_d;
    logic [7:0]       data_q, data_d;

    logic tick;
    logic curBit;
    logic lastSeg;
    logic nextBit;
    logic toIdle;

    assign tick = ce_i & motor_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            level_q  <= 1'b0;
            segCnt_q <= '0;
            segIdx_q <= '0;
            bitIdx_q <= '0;
            hdrCnt_q <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            segCnt_q <= segCnt_d;
            segIdx_q <= segIdx_d;
            bitIdx_q <= bitIdx_d;
            hdrCnt_q <= hdrCnt_d;
            data_q   <= data_d;
        end
    end

    // A 0 bit is two long segments, a 1 bit four short ones; both last 4*HALF_P ticks.
    always_comb begin
        case (state_q)
            START:   curBit = 1'b0;
            DATA:    curBit = data_q[bitIdx_q];
            default: curBit = 1'b1;
        endcase
        lastSeg = curBit ? (segIdx_q == 2'd3) : (segIdx_q == 2'd1);
    end

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        segCnt_d = segCnt_q;
        segIdx_d = segIdx_q;
        bitIdx_d = bitIdx_q;
        hdrCnt_d = hdrCnt_q;
        data_d   = data_q;
        nextBit  = 1'b1;
        toIdle   = 1'b0;

        if (abort_i) begin
            toIdle = 1'b1;
        end else if (state_q == IDLE) begin
            if (valid_i) begin
                segIdx_d = '0;
                bitIdx_d = '0;
                case (tag_i)
                    2'b00: begin
                        state_d  = START;
                        data_d   = data_i;
                        level_d  = 1'b1;
                        segCnt_d = SEG_LONG;
                    end
                    2'b01: begin
                        state_d  = HDR;
                        hdrCnt_d = 16'(SHORT_HDR);
                        level_d  = 1'b1;
                        segCnt_d = SEG_SHORT;
                    end
                    2'b10: begin
                        state_d  = HDR;
                        hdrCnt_d = 16'(LONG_HDR);
                        level_d  = 1'b1;
                        segCnt_d = SEG_SHORT;
                    end
                    default: ;
                endcase
            end
        end else if (tick) begin
            if (segCnt_q > SEG_W'(1)) begin
                segCnt_d = segCnt_q - SEG_W'(1);
            end else if (state_q == HDR) begin
                if (!segIdx_q[0]) begin
                    level_d  = 1'b0;
                    segIdx_d = 2'd1;
                    segCnt_d = SEG_SHORT;
                end else if (hdrCnt_q <= 16'd1) begin
                    toIdle = 1'b1;
                end else begin
                    hdrCnt_d = hdrCnt_q - 16'd1;
                    level_d  = 1'b1;
                    segIdx_d = 2'd0;
                    segCnt_d = SEG_SHORT;
                end
            end else if (!lastSeg) begin
                level_d  = ~level_q;
                segIdx_d = segIdx_q + 2'd1;
                segCnt_d = curBit ? SEG_SHORT : SEG_LONG;
            end else begin
                // Bit boundary: every bit starts high, length depends on the upcoming bit.
                level_d  = 1'b1;
                segIdx_d = 2'd0;
                case (state_q)
                    START: begin
                        state_d  = DATA;
                        bitIdx_d = 3'd0;
                        nextBit  = data_q[0];
                    end
                    DATA: begin
                        if (bitIdx_q == 3'd7) begin
                            state_d  = STOP;
                            bitIdx_d = 3'd0;
                        end else begin
                            bitIdx_d = bitIdx_q + 3'd1;
                            nextBit  = data_q[bitIdx_q + 3'd1];
                        end
                    end
                    default: begin
                        if (bitIdx_q == 3'd1) begin
                            toIdle = 1'b1;
                        end else begin
                            bitIdx_d = 3'd1;
                        end
                    end
                endcase
                segCnt_d = nextBit ? SEG_SHORT : SEG_LONG;
            end
        end

        if (toIdle) begin
            state_d  = IDLE;
            level_d  = 1'b0;
            segCnt_d = '0;
            segIdx_d = '0;
            bitIdx_d = '0;
            hdrCnt_d = '0;
        end
    end

    // The level survives a motor stop; only the pin is forced low.
    always_comb begin
        ready_o     = (state_q == IDLE);
        busy_o      = (state_q != IDLE);
        cas_audio_o = level_q & motor_i;
    end
endmodule

// File: tb/tb_cas_fsk_player.sv
// Directed bench for cas_fsk_player: table of items checked against a per-tick
// waveform model, plus back-to-back, motor pause, abort, ce gating and reset cases.
module tb_cas_fsk_player;
    localparam int HP = 4;

    logic       clk = 1'b0;
    logic       reset_n_i;
    logic       ce_i;
    logic       motor_i;
    logic       abort_i;
    logic [7:0] data_i;
    logic [1:0] tag_i;
    logic       valid_i;
    logic       ready_o;
    logic       cas_audio_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;
    int busyCnt, rises, waveErr, pauseErr;

    typedef struct {
        logic [1:0] tag;
        logic [7:0] data;
        int         expBusy;
        int         expRises;
    } VecT;

    VecT vecs[6];

    cas_fsk_player #(.HALF_P(HP), .LONG_HDR(20), .SHORT_HDR(10)) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n_i),
        .ce_i       (ce_i),
        .motor_i    (motor_i),
        .abort_i    (abort_i),
        .data_i     (data_i),
        .tag_i      (tag_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .cas_audio_o(cas_audio_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    // Expected tape level after k ticks of an item.
    function automatic logic expLevel(input logic [1:0] tag, input logic [7:0] data, input int k);
        int   bitNo;
        int   off;
        logic b;
        if (tag != 2'b00) return ((k % (2 * HP)) < HP);
        bitNo = k / (4 * HP);
        off   = k % (4 * HP);
        if (bitNo == 0)      b = 1'b0;
        else if (bitNo <= 8) b = data[bitNo - 1];
        else                 b = 1'b1;
        return b ? ((off % (2 * HP)) < HP) : (off < (2 * HP));
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] tag, input logic [7:0] data, input bit holdValid);
        @(negedge clk);
        tag_i   = tag;
        data_i  = data;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        if (!holdValid) valid_i = 1'b0;
    endtask

    // Samples on negedges while busy; motor-on samples are ticks, motor-off ones must be silent.
    task automatic observe(input logic [1:0] tag, input logic [7:0] data, input int pauseAt,
                           input int pauseLen, input int stopAt,
                           output int oBusy, output int oRises, output int oWave, output int oPause);
        int   idx;
        int   guard;
        int   pauseLeft;
        logic prev;
        idx = 0; guard = 0; prev = 1'b0;
        oRises = 0; oWave = 0; oPause = 0;
        pauseLeft = 0;
        @(negedge clk);
        while (busy_o && idx < stopAt && guard < 5000) begin
            guard++;
            if (motor_i) begin
                if (cas_audio_o !== expLevel(tag, data, idx)) oWave++;
                if (cas_audio_o && !prev) oRises++;
                prev = cas_audio_o;
                idx++;
                if (idx == pauseAt) begin
                    motor_i   = 1'b0;
                    pauseLeft = pauseLen;
                end
            end else begin
                if (cas_audio_o !== 1'b0) oPause++;
                pauseLeft--;
                if (pauseLeft <= 0) motor_i = 1'b1;
            end
            @(negedge clk);
        end
        oBusy = idx;
    endtask

    initial begin
        vecs[0] = '{2'b01, 8'h00, 80, 10};
        vecs[1] = '{2'b10, 8'h00, 160, 20};
        vecs[2] = '{2'b00, 8'hA5, 176, 17};
        vecs[3] = '{2'b00, 8'h01, 176, 14};
        vecs[4] = '{2'b00, 8'hFF, 176, 21};
        vecs[5] = '{2'b11, 8'h5A, 0, 0};

        reset_n_i = 1'b0; ce_i = 1'b1; motor_i = 1'b1; abort_i = 1'b0;
        data_i = 8'h00; tag_i = 2'b00; valid_i = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy/ready/audio", {busy_o, ready_o, cas_audio_o}, 3'b010);
        reset_n_i = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].tag, vecs[i].data, 1'b0);
            observe(vecs[i].tag, vecs[i].data, -1, 0, 100000, busyCnt, rises, waveErr, pauseErr);
            checkOutput($sformatf("vec%0d busy ticks", i), busyCnt, vecs[i].expBusy);
            checkOutput($sformatf("vec%0d rising edges", i), rises, vecs[i].expRises);
            checkOutput($sformatf("vec%0d wave errors", i), waveErr, 0);
            checkOutput($sformatf("vec%0d idle ready/audio", i), {ready_o, cas_audio_o}, 2'b10);
        end

        $display("[TB] back-to-back 0x00 then 0xFF");
        applyStimulus(2'b00, 8'h00, 1'b1);
        data_i = 8'hFF;
        observe(2'b00, 8'h00, -1, 0, 100000, busyCnt, rises, waveErr, pauseErr);
        checkOutput("b2b first busy", busyCnt, 176);
        checkOutput("b2b first rises", rises, 13);
        checkOutput("b2b first wave", waveErr, 0);
        checkOutput("b2b gap ready", ready_o, 1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        checkOutput("b2b second accepted after 1 clk", busy_o, 1);
        observe(2'b00, 8'hFF, -1, 0, 100000, busyCnt, rises, waveErr, pauseErr);
        checkOutput("b2b second busy", busyCnt, 176);
        checkOutput("b2b second rises", rises, 21);
        checkOutput("b2b second wave", waveErr, 0);

        $display("[TB] motor pause mid data bit");
        applyStimulus(2'b00, 8'h00, 1'b0);
        observe(2'b00, 8'h00, 20, 50, 100000, busyCnt, rises, waveErr, pauseErr);
        checkOutput("motor frame ticks", busyCnt, 176);
        checkOutput("motor rises", rises, 13);
        checkOutput("motor wave", waveErr, 0);
        checkOutput("motor pause silent", pauseErr, 0);

        $display("[TB] accept with motor off");
        motor_i = 1'b0;
        applyStimulus(2'b01, 8'h00, 1'b0);
        checkOutput("motor-off accept busy/ready/audio", {busy_o, ready_o, cas_audio_o}, 3'b100);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("motor-off held audio", {busy_o, cas_audio_o}, 2'b10);
        motor_i = 1'b1;
        observe(2'b01, 8'h00, -1, 0, 100000, busyCnt, rises, waveErr, pauseErr);
        checkOutput("motor-off header ticks", busyCnt, 80);
        checkOutput("motor-off header wave", waveErr, 0);

        $display("[TB] abort mid data");
        applyStimulus(2'b00, 8'hA5, 1'b0);
        observe(2'b00, 8'hA5, -1, 0, 40, busyCnt, rises, waveErr, pauseErr);
        checkOutput("abort pre wave", waveErr, 0);
        abort_i = 1'b1; valid_i = 1'b1; tag_i = 2'b00; data_i = 8'h3C;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        checkOutput("abort idle busy/ready/audio", {busy_o, ready_o, cas_audio_o}, 3'b010);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        checkOutput("abort next accept", busy_o, 1);
        observe(2'b00, 8'h3C, -1, 0, 100000, busyCnt, rises, waveErr, pauseErr);
        checkOutput("post-abort frame ticks", busyCnt, 176);
        checkOutput("post-abort wave", waveErr, 0);

        $display("[TB] ce gating");
        ce_i = 1'b0;
        applyStimulus(2'b01, 8'h00, 1'b0);
        repeat (20) @(negedge clk);
        checkOutput("no ticks without ce", {busy_o, cas_audio_o}, 2'b11);
        abort_i = 1'b1;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        ce_i = 1'b1;
        checkOutput("abort with ce low", {busy_o, ready_o, cas_audio_o}, 3'b010);

        $display("[TB] reset mid header");
        applyStimulus(2'b10, 8'h00, 1'b0);
        observe(2'b10, 8'h00, -1, 0, 10, busyCnt, rises, waveErr, pauseErr);
        checkOutput("pre-reset header wave", waveErr, 0);
        #2;
        reset_n_i = 1'b0;
        #1;
        checkOutput("async reset busy/ready/audio", {busy_o, ready_o, cas_audio_o}, 3'b010);
        @(negedge clk);
        reset_n_i = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
